// File: rtl/rv_fetch_ctrl.sv
// Fetch sequencer: turns the IF-stage PC into req/gnt/rvalid memory reads, one outstanding at a time.
// Define RV_FETCH_PERF_EN to add the fetch and stall performance counters.
module rv_fetch_ctrl #(
    parameter int unsigned BW_ADDR  = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic               i_fc_clk,
    input  logic               i_fc_rstn,
    input  logic [BW_ADDR-1:0] i_fc_ra,
    input  logic               i_fc_redirect,
    input  logic               i_fc_pipe_stall,
    output logic [31:0]        o_fc_instr,
    output logic               o_fc_stall,
    output logic               o_fc_mem_req,
    output logic [BW_ADDR-1:0] o_fc_mem_addr,
    input  logic               i_fc_mem_gnt,
    input  logic               i_fc_mem_rvalid,
    input  logic [31:0]        i_fc_mem_rdata,
`ifdef RV_FETCH_PERF_EN
    output logic [31:0]        o_fc_fetch_cnt,
    output logic [31:0]        o_fc_stall_cnt,
`endif
    output logic               o_fc_err
);

    localparam logic [31:0] Nop      = 32'h0000_0013;
    localparam logic [15:0] WaitLast = 16'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        consume;
    logic        timeout;

    assign o_fc_mem_addr = i_fc_ra;
    assign o_fc_err      = err_q;
    assign timeout       = (cnt_q == WaitLast);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        o_fc_instr   = Nop;
        o_fc_stall   = 1'b1;
        o_fc_mem_req = 1'b0;
        consume      = 1'b0;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                o_fc_mem_req = 1'b1;
                if (i_fc_mem_gnt) begin
                    cnt_d   = '0;
                    state_d = i_fc_redirect ? StDiscard : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                if (i_fc_mem_rvalid) begin
                    state_d = StReq;
                    if (!i_fc_redirect) begin
                        if (!i_fc_pipe_stall) begin
                            o_fc_instr = i_fc_mem_rdata;
                            o_fc_stall = 1'b0;
                            consume    = 1'b1;
                        end else begin
                            buf_d   = i_fc_mem_rdata;
                            state_d = StHold;
                        end
                    end
                end else if (timeout) begin
                    // Give up on this response and retry; a late rvalid lands in REQ and is ignored.
                    err_d   = 1'b1;
                    state_d = StReq;
                end else if (i_fc_redirect) begin
                    state_d = StDiscard;
                end
            end
            StHold: begin
                o_fc_instr = buf_q;
                o_fc_stall = 1'b0;
                if (i_fc_redirect || !i_fc_pipe_stall) begin
                    state_d = StReq;
                end
                consume = !i_fc_redirect && !i_fc_pipe_stall;
            end
            StDiscard: begin
                cnt_d = cnt_q + 16'd1;
                if (i_fc_mem_rvalid) begin
                    state_d = StReq;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_fc_clk or negedge i_fc_rstn) begin
        if (!i_fc_rstn) begin
            state_q <= StIdle;
            buf_q   <= Nop;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef RV_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (consume) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (o_fc_stall && (state_q != StIdle)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_fc_clk or negedge i_fc_rstn) begin
        if (!i_fc_rstn) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fc_fetch_cnt = fetch_cnt_q;
    assign o_fc_stall_cnt = stall_cnt_q;
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed scenarios plus randomized traffic checked against a transaction-level fetch model.
module tb_rv_fetch_ctrl;

    localparam int unsigned MaxWait = 4;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        clk, rstn;
    logic [31:0] ra, instr, addr, rdata;
    logic        redirect, pstall, stall, req, gnt, rvalid, err;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [31:0] acc_addr = '0;

    rv_fetch_ctrl #(.BW_ADDR(32), .MAX_WAIT(MaxWait)) dut (
        .i_fc_clk        (clk),
        .i_fc_rstn       (rstn),
        .i_fc_ra         (ra),
        .i_fc_redirect   (redirect),
        .i_fc_pipe_stall (pstall),
        .o_fc_instr      (instr),
        .o_fc_stall      (stall),
        .o_fc_mem_req    (req),
        .o_fc_mem_addr   (addr),
        .i_fc_mem_gnt    (gnt),
        .i_fc_mem_rvalid (rvalid),
        .i_fc_mem_rdata  (rdata),
`ifdef RV_FETCH_PERF_EN
        .o_fc_fetch_cnt  (fetch_cnt),
        .o_fc_stall_cnt  (stall_cnt),
`endif
        .o_fc_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side view of accepted transactions.
    always @(posedge clk) begin
        if (rstn && req && gnt) begin
            acc_cnt  <= acc_cnt + 1;
            acc_addr <= addr;
        end
    end

    task automatic set_in(input logic g, input logic v, input logic [31:0] d,
                          input logic rd, input logic ps, input logic [31:0] a);
        gnt = g; rvalid = v; rdata = d; redirect = rd; pstall = ps; ra = a;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        checks++; if (instr !== Nop) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, Nop); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", stall); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", req); end
        advance();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", req); end
    endtask

    task automatic test_basic();
        set_in(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin errors++; $display("FAIL basic_req: got req=%b addr=%h want 1 0", req, addr); end
        advance();
        set_in(0, 1, 32'h0050_0093, 0, 0, 32'h0);
        @(negedge clk);
        checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h want 00500093", instr); end
        checks++; if (stall !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL basic_stall: got stall=%b req=%b want 0 0", stall, req); end
        advance();
        set_in(0, 0, 0, 0, 0, 32'h4);
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL basic_rereq: got req=%b addr=%h want 1 4", req, addr); end
        advance();
    endtask

    task automatic test_gnt_delay();
        int base;
        base = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            set_in((i == 3), 0, 0, 0, 0, 32'h100);
            @(negedge clk);
            checks++; if (req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL gnt_delay_req%0d: got req=%b stall=%b want 1 1", i, req, stall); end
            advance();
        end
        set_in(0, 0, 0, 0, 0, 32'h100);
        @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL gnt_delay_wait_req: got %b want 0", req); end
        checks++; if (acc_cnt !== base + 1 || acc_addr !== 32'h100) begin errors++; $display("FAIL gnt_delay_txn: got n=%0d addr=%h want %0d 00000100", acc_cnt - base, acc_addr, 1); end
        advance();
    endtask

    task automatic test_hold();
        set_in(0, 1, 32'h00A0_0113, 0, 1, 32'h104);
        @(negedge clk);
        checks++; if (stall !== 1'b1 || instr !== Nop) begin errors++; $display("FAIL hold_capture: got stall=%b instr=%h want 1 %h", stall, instr, Nop); end
        advance();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, (i == 0), 32'h104);
            @(negedge clk);
            checks++; if (instr !== 32'h00A0_0113 || stall !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL hold_out%0d: got instr=%h stall=%b req=%b want 00a00113 0 0", i, instr, stall, req); end
            advance();
        end
        set_in(0, 0, 0, 0, 0, 32'h104);
        @(negedge clk);
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL hold_exit_req: got %b want 1", req); end
        advance();
    endtask

    task automatic test_redirect_discard();
        set_in(1, 0, 0, 0, 0, 32'h200);
        advance();
        set_in(0, 0, 0, 1, 0, 32'h300);
        @(negedge clk);
        checks++; if (stall !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL redir_wait: got stall=%b req=%b want 1 0", stall, req); end
        advance();
        set_in(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h300);
        @(negedge clk);
        checks++; if (instr !== Nop || stall !== 1'b1) begin errors++; $display("FAIL redir_drop: got instr=%h stall=%b want %h 1", instr, stall, Nop); end
        advance();
        set_in(0, 0, 0, 0, 0, 32'h300);
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h300) begin errors++; $display("FAIL redir_rereq: got req=%b addr=%h want 1 00000300", req, addr); end
        advance();
    endtask

    task automatic test_timeout();
        set_in(1, 0, 0, 0, 0, 32'h400);
        advance();
        for (int i = 0; i < int'(MaxWait); i++) begin
            set_in(0, 0, 0, 0, 0, 32'h400);
            @(negedge clk);
            checks++; if (err !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d: got err=%b req=%b want 0 0", i, err, req); end
            advance();
        end
        set_in(0, 1, 32'h1234_5678, 0, 0, 32'h400);
        @(negedge clk);
        checks++; if (err !== 1'b1 || req !== 1'b1) begin errors++; $display("FAIL timeout_retry: got err=%b req=%b want 1 1", err, req); end
        checks++; if (instr !== Nop || stall !== 1'b1) begin errors++; $display("FAIL timeout_stray: got instr=%h stall=%b want %h 1", instr, stall, Nop); end
        advance();
        set_in(1, 0, 0, 0, 0, 32'h400);
        advance();
        set_in(0, 1, 32'h0000_0093, 0, 0, 32'h404);
        @(negedge clk);
        checks++; if (instr !== 32'h93 || stall !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got instr=%h stall=%b err=%b want 00000093 0 1", instr, stall, err); end
        advance();
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 0, 0, 32'h500);
        advance();
        set_in(0, 1, 32'h1111_1111, 0, 0, 32'h504);
        @(negedge clk);
        checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL areset_pre: got %h want 11111111", instr); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (instr !== Nop || stall !== 1'b1 || req !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL areset_now: got instr=%h stall=%b req=%b err=%b want %h 1 0 0", instr, stall, req, err, Nop);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 32'h0);
        rstn = 1'b1;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL areset_idle: got %b want 0", req); end
        advance();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL areset_req: got %b want 1", req); end
    endtask

    task automatic test_random();
        // Model: a fetch is either not yet issued, outstanding (possibly stale), or held for the IF stage.
        bit started = 0, outstanding = 0, stale = 0, held = 0, m_err = 0;
        logic [31:0] held_data = Nop;
        int wait_cnt = 0;
        logic [31:0] m_fetch = 0, m_stall = 0;
        logic        e_req, e_stall;
        logic [31:0] e_instr;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_in(($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 35), $urandom,
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 40), $urandom);
            @(negedge clk);
            e_req = 0; e_stall = 1; e_instr = Nop;
            if (!started) begin
            end else if (held) begin
                e_stall = 0; e_instr = held_data;
            end else if (!outstanding) begin
                e_req = 1;
            end else if (rvalid && !stale && !redirect && !pstall) begin
                e_stall = 0; e_instr = rdata;
            end
            checks++; if (req !== e_req || stall !== e_stall || instr !== e_instr || err !== m_err || addr !== ra) begin
                errors++;
                $display("FAIL rand_cyc%0d: got req=%b stall=%b instr=%h err=%b addr=%h want %b %b %h %b %h",
                         cyc, req, stall, instr, err, addr, e_req, e_stall, e_instr, m_err, ra);
            end
`ifdef RV_FETCH_PERF_EN
            checks++; if (fetch_cnt !== m_fetch || stall_cnt !== m_stall) begin
                errors++; $display("FAIL rand_perf%0d: got %0d %0d want %0d %0d", cyc, fetch_cnt, stall_cnt, m_fetch, m_stall);
            end
`endif
            if (started && e_stall) m_stall++;
            if (!started) begin
                started = 1;
            end else if (held) begin
                if (!redirect && !pstall) m_fetch++;
                if (redirect || !pstall) held = 0;
            end else if (!outstanding) begin
                if (gnt) begin
                    outstanding = 1; stale = redirect; wait_cnt = 0;
                end
            end else if (rvalid) begin
                outstanding = 0;
                if (!stale && !redirect) begin
                    if (pstall) begin
                        held = 1; held_data = rdata;
                    end else begin
                        m_fetch++;
                    end
                end
            end else begin
                wait_cnt++;
                if (wait_cnt == int'(MaxWait)) begin
                    m_err = 1; outstanding = 0;
                end else if (redirect) begin
                    stale = 1;
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_delay();
        test_hold();
        test_redirect_discard();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
